acq_sched: RTL and testbench
============================

# acq_sched

Acquisition scheduler that owns the free-running 32-bit timer in the sig_acq datapath. It drives the timer's clear/enable, divides the timer's 10 ms tick pulse down to a programmable sample period, and issues timestamped sample triggers to the capture logic over a req/ack handshake. It supports finite or continuous runs, stop, and overrun detection.

## Interface
- `TICK_W`, default 16: width of the period and sample-count registers.
- `TMO_CYC`, default 1024: ack-timeout limit in clk cycles. Used only with `ACQ_SCHED_TMO_EN`.
- `clk`  in  1: working clock, 110.592 MHz.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle run request. Ignored unless in IDLE.
- `stop`  in  1: one-cycle abort request.
- `period`  in  TICK_W: ticks per sample. Sampled on an accepted `start`. A value of 0 causes `start` to be rejected.
- `nsamp`  in  TICK_W: samples per run. Sampled on an accepted `start`. 0 means continuous.
- `tmr_clr`  out  1: timer clear.
- `tmr_ena`  out  1: timer enable.
- `tmr_pulse_10ms`  in  1: timer tick, one cycle wide.
- `tmr_count`  in  32: timer value.
- `trig`  out  1: sample request. Held until acknowledged.
- `trig_ack`  in  1: sample accepted.
- `stamp`  out  32: `tmr_count` captured at trigger assertion.
- `busy`  out  1: high in any state except IDLE.
- `done`  out  1: one-cycle pulse when a finite run completes.
- `err_ovr`  out  1: sticky. Set when a period elapses while `trig` is pending.
- `err_tmo`  out  1: sticky ack-timeout flag. Present only with `ACQ_SCHED_TMO_EN`.

## Operation
- States: IDLE, CLEAR, RUN, WAIT_ACK, DONE.
- **IDLE**
  - `tmr_ena`=0.
  - `start` with `period`≠0 latches `period`/`nsamp`, clears `err_ovr`/`err_tmo`, and goes to CLEAR.
- **CLEAR**
  - `tmr_clr`=1 for exactly one cycle.
  - Tick counter and sample counter are zeroed.
  - Next state is RUN.
- **RUN**
  - `tmr_ena`=1.
  - Each `tmr_pulse_10ms` increments the tick counter.
  - When a pulse arrives with tick counter = period−1: tick counter wraps to 0, `trig` rises next cycle, `stamp` gets `tmr_count` from the pulse cycle, and the state goes to WAIT_ACK.
- **WAIT_ACK**
  - `tmr_ena`=1 and ticks keep counting.
  - When `trig_ack` is high with `trig` high: `trig` drops next cycle and the sample counter increments.
  - If the new sample count = `nsamp` and `nsamp`≠0, go to DONE. Otherwise go to RUN.
  - If the period elapses again before ack: set `err_ovr`, drop that trigger, and keep waiting for the pending ack. `stamp` is not updated.
- **DONE**
  - `done`=1 and `tmr_ena`=0 for one cycle.
  - Next state is IDLE.
- `stop` in any non-IDLE state:
  - Next state is IDLE.
  - `trig`, `tmr_ena` and `tmr_clr` are 0 next cycle.
  - No `done` pulse.
  - `stop` takes priority over a simultaneous `trig_ack` or tick.
- `start` while busy is ignored. `start` and `stop` in the same cycle in IDLE: `start` wins.
- `trig_ack` without `trig` is ignored.
- Tick and sample counters are unsigned TICK_W bits. With `nsamp`=0 the sample counter wraps silently.

## Timing
- Reset values: `tmr_clr`, `tmr_ena`, `trig`, `busy`, `done`, `err_ovr`, `err_tmo` are 0; `stamp` is 0; state is IDLE.
- Reset mid-run returns everything to these values immediately (asynchronous).
- `start` → `tmr_clr` high on cycle +1 → `tmr_ena` high from cycle +2.
- Tick pulse completing a period → `trig` high 1 cycle later.
- Ack → `trig` low on the next edge. The earliest next trigger is the next period boundary.
- All outputs are registered.

## Configuration
- `ACQ_SCHED_TMO_EN` defined:
  - A cycle counter runs in WAIT_ACK.
  - After `TMO_CYC` cycles without ack: `err_tmo`=1, `trig`=0, state → IDLE, no `done`.
- `ACQ_SCHED_TMO_EN` undefined:
  - No counter is built.
  - `err_tmo` port is absent.
  - WAIT_ACK waits indefinitely.

## Structure
- Package `acq_sched_pkg` holds:
  - state encoding constants `ST_IDLE`..`ST_DONE`;
  - default `TICK_W`;
  - default `TMO_CYC`.
- Sub-module `acq_tick_div`:
  - inputs: tick pulse, load/clear, period;
  - output: one-cycle period-elapsed strobe.
- The FSM, sample counter, stamp register and error flags stay in `acq_sched`.

## Test plan
- `period`=3, `nsamp`=2, immediate ack:
  - `tmr_clr` one cycle after `start`;
  - `trig` after the 3rd and 6th ticks;
  - `stamp` equals `tmr_count` at those tick cycles;
  - `done` one cycle after the 2nd ack, then `busy`=0.
- `period`=1, `nsamp`=0, ack delayed 3 ticks:
  - `err_ovr` set after the 2nd tick;
  - exactly one `trig` per ack;
  - run continues until `stop`.
- `stop` asserted in WAIT_ACK with `trig_ack` in the same cycle:
  - IDLE next cycle, `trig`=0, `tmr_ena`=0;
  - no `done`, sample count not reported.
- `start` with `period`=0 → stays IDLE, `busy`=0. `start` during RUN → ignored and the run is unaffected.
- `rst` low mid-WAIT_ACK → all outputs 0 immediately. After release, a fresh `start` behaves as in scenario 1.
- With `ACQ_SCHED_TMO_EN` and `TMO_CYC`=16, no ack → `err_tmo`=1 and IDLE 16 cycles after `trig` rises.

Source files
------------

// File: rtl/acq_sched_pkg.sv
// rtl/acq_sched_pkg.sv - shared state encoding and parameter defaults for acq_sched
package acq_sched_pkg;

  localparam int TICK_W_DEF  = 16;
  localparam int TMO_CYC_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_WAIT_ACK,
    ST_DONE
  } state_t;

endpackage

// File: rtl/acq_tick_div.sv
// rtl/acq_tick_div.sv - divides the 10 ms timer tick down to a period-elapsed strobe
module acq_tick_div
  import acq_sched_pkg::*;
#(
  parameter int TICK_W = TICK_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              ena,
  input  logic              tick,
  input  logic [TICK_W-1:0] period,
  output logic              elapsed
);

  logic [TICK_W-1:0] cnt;

  // Combinational so the scheduler can raise trig on the edge right after the tick
  assign elapsed = ena && tick && (cnt == period - TICK_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (ena && tick) begin
      cnt <= elapsed ? '0 : cnt + TICK_W'(1);
    end
  end

endmodule

// File: rtl/acq_sched.sv
// rtl/acq_sched.sv - acquisition scheduler: timer control, sample triggers, overrun; ack timeout with ACQ_SCHED_TMO_EN
module acq_sched
  import acq_sched_pkg::*;
#(
  parameter int TICK_W  = TICK_W_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [TICK_W-1:0] period,
  input  logic [TICK_W-1:0] nsamp,
  output logic              tmr_clr,
  output logic              tmr_ena,
  input  logic              tmr_pulse_10ms,
  input  logic [31:0]       tmr_count,
  output logic              trig,
  input  logic              trig_ack,
  output logic [31:0]       stamp,
  output logic              busy,
  output logic              done,
`ifdef ACQ_SCHED_TMO_EN
  output logic              err_tmo,
`endif
  output logic              err_ovr
);

  state_t            state, state_n;
  logic [TICK_W-1:0] period_q, nsamp_q, samp_cnt, samp_inc;
  logic              elapsed, div_clr, div_ena, start_ok, tmo_hit;

  assign samp_inc = samp_cnt + TICK_W'(1);
  assign start_ok = (state == ST_IDLE) && start && (period != '0);
  assign div_clr  = (state == ST_IDLE) || (state == ST_CLEAR);
  assign div_ena  = (state == ST_RUN) || (state == ST_WAIT_ACK);

  acq_tick_div #(.TICK_W(TICK_W)) u_div (
    .clk     (clk),
    .rst     (rst),
    .clr     (div_clr),
    .ena     (div_ena),
    .tick    (tmr_pulse_10ms),
    .period  (period_q),
    .elapsed (elapsed)
  );

`ifdef ACQ_SCHED_TMO_EN
  logic [31:0] tmo_cnt;

  assign tmo_hit = (state == ST_WAIT_ACK) && !trig_ack && (tmo_cnt == 32'(TMO_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
      err_tmo <= 1'b0;
    end else begin
      if (state != ST_WAIT_ACK || trig_ack || tmo_hit) tmo_cnt <= '0;
      else tmo_cnt <= tmo_cnt + 32'd1;
      if (start_ok) err_tmo <= 1'b0;
      else if (tmo_hit && !stop) err_tmo <= 1'b1;
    end
  end
`else
  logic unused_tmo;

  // The timeout limit only matters when the timeout counter is built
  assign unused_tmo = (TMO_CYC > 0);
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:     if (start_ok) state_n = ST_CLEAR;
      ST_CLEAR:    state_n = ST_RUN;
      ST_RUN:      if (elapsed) state_n = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (trig_ack) state_n = (nsamp_q != '0 && samp_inc == nsamp_q) ? ST_DONE : ST_RUN;
        else if (tmo_hit) state_n = ST_IDLE;
      end
      ST_DONE:     state_n = ST_IDLE;
      default:     state_n = ST_IDLE;
    endcase
    if (stop && state != ST_IDLE) state_n = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      tmr_clr  <= 1'b0;
      tmr_ena  <= 1'b0;
      trig     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_ovr  <= 1'b0;
      stamp    <= '0;
      period_q <= '0;
      nsamp_q  <= '0;
      samp_cnt <= '0;
    end else begin
      state   <= state_n;
      tmr_clr <= (state_n == ST_CLEAR);
      tmr_ena <= (state_n == ST_RUN) || (state_n == ST_WAIT_ACK);
      trig    <= (state_n == ST_WAIT_ACK);
      busy    <= (state_n != ST_IDLE);
      done    <= (state_n == ST_DONE);
      if (start_ok) begin
        period_q <= period;
        nsamp_q  <= nsamp;
        err_ovr  <= 1'b0;
      end else if (state == ST_WAIT_ACK && elapsed && !stop) begin
        err_ovr <= 1'b1;
      end
      if (state == ST_CLEAR) samp_cnt <= '0;
      else if (state == ST_WAIT_ACK && trig_ack && !stop) samp_cnt <= samp_inc;
      if (state == ST_RUN && state_n == ST_WAIT_ACK) stamp <= tmr_count;
    end
  end

endmodule

// File: tb/tb_acq_sched.sv
// tb/tb_acq_sched.sv - scoreboard bench for acq_sched with a behavioural run model
`timescale 1ns/1ps
module tb_acq_sched;

  localparam int TW  = 16;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0, stop = 1'b0, tick = 1'b0, trig_ack = 1'b0;
  logic [TW-1:0] period = '0, nsamp = '0;
  logic [31:0]   tmr_count = '0;
  logic          tmr_clr, tmr_ena, trig, busy, done, err_ovr, tmo_obs;
  logic [31:0]   stamp;

`ifdef ACQ_SCHED_TMO_EN
  logic err_tmo;
  assign tmo_obs = err_tmo;
`else
  assign tmo_obs = 1'b0;
`endif

  acq_sched #(.TICK_W(TW), .TMO_CYC(TMO)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .stop           (stop),
    .period         (period),
    .nsamp          (nsamp),
    .tmr_clr        (tmr_clr),
    .tmr_ena        (tmr_ena),
    .tmr_pulse_10ms (tick),
    .tmr_count      (tmr_count),
    .trig           (trig),
    .trig_ack       (trig_ack),
    .stamp          (stamp),
    .busy           (busy),
    .done           (done),
`ifdef ACQ_SCHED_TMO_EN
    .err_tmo        (err_tmo),
`endif
    .err_ovr        (err_ovr)
  );

  always #5 clk = ~clk;

  // kind 0: trigger rise with stamp, kind 1: done pulse
  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] stamp;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0, fails = 0, cyc = 0;

  // Reference run model: phase 0 idle, 1 clearing, 2 running, 3 finishing
  int  ph = 0, ticks = 0, samples = 0, m_per = 0, m_ns = 0, age = 0;
  bit  pend = 0, m_ovr = 0, m_tmo = 0;

  task model_step();
    bit pb, acked, el;
    case (ph)
      0: if (start && period != 0) begin
        m_per = int'(period); m_ns = int'(nsamp); m_ovr = 0; m_tmo = 0; ph = 1;
      end
      1: begin
        ticks = 0; samples = 0; pend = 0; ph = stop ? 0 : 2;
      end
      2: if (stop) begin
        ph = 0; pend = 0;
      end else begin
        pb = pend; acked = pend && trig_ack; el = 0;
        if (tick) begin
          ticks++;
          if (ticks == m_per) begin ticks = 0; el = 1; end
        end
        if (el && pb) m_ovr = 1;
        if (acked) begin
          pend = 0;
          samples = (samples + 1) % 65536;
          if (m_ns != 0 && samples == m_ns) begin
            ph = 3;
            exp_q.push_back('{1, cyc, 32'd0});
          end
        end else if (pb) begin
`ifdef ACQ_SCHED_TMO_EN
          age++;
          if (age == TMO) begin pend = 0; ph = 0; m_tmo = 1; end
`endif
        end else if (el) begin
          pend = 1; age = 0;
          exp_q.push_back('{0, cyc, tmr_count});
        end
      end
      default: ph = 0;
    endcase
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      ph = 0; pend = 0; m_ovr = 0; m_tmo = 0;
      exp_q.delete();
    end else begin
      model_step();
    end
  end

  // Stimulus background: timer value, tick pulses and ack policy
  int ack_mode = 0, ack_dly = 0, tick_gap = 4, tcnt = 0, trig_age = 0;

  always @(negedge clk) begin
    tmr_count = $urandom;
    if (tick_gap == 0) tick = ($urandom % 3 == 0);
    else tick = (tcnt % tick_gap == 0);
    tcnt++;
    trig_age = trig ? trig_age + 1 : 0;
    case (ack_mode)
      0: trig_ack = trig;
      1: trig_ack = trig && (trig_age > ack_dly);
      2: trig_ack = ($urandom % 4 == 0);
      3: trig_ack = 1'b0;
      default: ;
    endcase
  end

  task check_event(input int k, input logic [31:0] s);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL event cyc=%0d got kind=%0d exp none", cyc, k);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || (k == 0 && e.stamp != s)) begin
        fails++;
        $display("FAIL event got kind=%0d cyc=%0d stamp=%h exp kind=%0d cyc=%0d stamp=%h",
                 k, cyc, s, e.kind, e.cyc, e.stamp);
      end
    end
  endtask

  logic trig_d = 1'b0;
  logic [6:0] got_lv, exp_lv;

  always @(negedge clk) begin
    if (rst) begin
      got_lv = {busy, tmr_clr, tmr_ena, trig, done, err_ovr, tmo_obs};
      exp_lv = {ph != 0, ph == 1, ph == 2, pend, ph == 3, m_ovr, m_tmo};
      tests++;
      if (got_lv !== exp_lv) begin
        fails++;
        $display("FAIL levels cyc=%0d got=%b exp=%b (busy,clr,ena,trig,done,ovr,tmo)", cyc, got_lv, exp_lv);
      end
      if (trig && !trig_d) check_event(0, stamp);
      if (done) check_event(1, stamp);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        tests++; fails++;
        $display("FAIL missing kind=%0d got none exp cyc=%0d", exp_q[0].kind, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
    end
    trig_d = trig;
  end

  task do_start(input int p, input int n);
    @(negedge clk);
    period = TW'(p); nsamp = TW'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task do_stop();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask

  task automatic wait_trig(input int lim);
    int n = 0;
    while (!trig && n < lim) begin @(negedge clk); n++; end
    tests++;
    if (!trig) begin
      fails++;
      $display("FAIL wait_trig got trig=0 exp trig=1 within %0d cycles", lim);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;

    // Finite run, period 3, two samples, immediate ack
    ack_mode = 0; tick_gap = 4;
    do_start(3, 2);
    repeat (40) @(negedge clk);

    // Continuous single-tick period with late acks to provoke overrun
    ack_mode = 1; ack_dly = 9; tick_gap = 3;
    do_start(1, 0);
    repeat (60) @(negedge clk);
    do_stop();
    repeat (3) @(negedge clk);

    // Stop colliding with ack in the waiting state
    ack_mode = 3; tick_gap = 2;
    do_start(1, 0);
    wait_trig(50);
    ack_mode = 5;
    @(negedge clk);
    trig_ack = 1'b1; stop = 1'b1;
    @(negedge clk);
    trig_ack = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);

    // Rejected start, then start while running
    ack_mode = 0; tick_gap = 4;
    do_start(0, 1);
    repeat (3) @(negedge clk);
    do_start(2, 3);
    repeat (5) @(negedge clk);
    do_start(1, 1);
    repeat (40) @(negedge clk);

    // Asynchronous reset while waiting for ack, then a fresh run
    ack_mode = 3; tick_gap = 2;
    do_start(2, 0);
    wait_trig(50);
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({busy, tmr_clr, tmr_ena, trig, done, err_ovr, tmo_obs} !== 7'b0 || stamp !== 32'd0) begin
      fails++;
      $display("FAIL reset got flags=%b stamp=%h exp all zero",
               {busy, tmr_clr, tmr_ena, trig, done, err_ovr, tmo_obs}, stamp);
    end
    @(posedge clk); @(posedge clk); @(negedge clk);
    #2 rst = 1'b1;
    ack_mode = 0; tick_gap = 4;
    do_start(3, 2);
    repeat (40) @(negedge clk);

`ifdef ACQ_SCHED_TMO_EN
    // No ack at all: run should time out
    ack_mode = 3; tick_gap = 5;
    do_start(1, 0);
    repeat (40) @(negedge clk);
`endif

    // Randomized runs
    for (int it = 0; it < 40; it++) begin
      tick_gap = 0;
      ack_mode = ($urandom % 2 == 0) ? 2 : 1;
      ack_dly = $urandom_range(0, 6);
      do_start($urandom_range(1, 4), $urandom_range(0, 3));
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        start = ($urandom % 16 == 0);
        period = TW'($urandom_range(0, 4));
        stop = ($urandom % 50 == 0);
      end
      @(negedge clk);
      start = 1'b0; stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      repeat (3) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending events exp 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
